// File: rtl/scoreboard_regfile.sv
// Decode-stage register file with per-register in-flight write counters.
// Reads are combinational; pending status lets decode stall on RAW hazards.
module scoreboard_regfile #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int NREGS   = 2 ** ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD-1:0]          rd_use,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    output logic                       stall,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       flush,
    output logic [NREGS-1:0]           pending_mask,
    output logic                       iss_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  cnt  [NREGS];
    logic [NREGS-1:0]  inc_vec;
    logic [NREGS-1:0]  dec_vec;
    logic              wr_eff;

    assign wr_eff = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        inc_vec      = '0;
        dec_vec      = '0;
        pending_mask = '0;
        for (int r = 0; r < NREGS; r++) begin
            inc_vec[r]      = iss_en && (iss_addr == ADDR_W'(r)) && !((ZERO_REG != 0) && (r == 0));
            dec_vec[r]      = wr_en && (wr_addr == ADDR_W'(r)) && (cnt[r] != '0);
            pending_mask[r] = (cnt[r] != '0);
        end
    end

    // NOTE: the data array is reset too, because a freshly reset file must read back zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            iss_ovf <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
            if (wr_eff)
                regs[wr_addr] <= wr_data;
            for (int r = 0; r < NREGS; r++) begin
                if (flush) begin
                    cnt[r] <= '0;
                end else if (inc_vec[r] && !dec_vec[r]) begin
                    if (cnt[r] == CNT_MAX)
                        iss_ovf <= 1'b1;
                    else
                        cnt[r] <= cnt[r] + CNT_ONE;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Forwarding hides the last outstanding write in the cycle it resolves.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        logic              hit;

        assign addr    = rd_addr[i*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign hit     = (BYPASS != 0) && wr_en && (wr_addr == addr);

        assign rd_data[i*DATA_W +: DATA_W] = is_zero ? '0 : (hit ? wr_data : regs[addr]);
        assign rd_pending[i] = !is_zero && (cnt[addr] != '0) && !(hit && (cnt[addr] == CNT_ONE));
    end

    assign stall = |(rd_use & rd_pending);

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile; a BYPASS=0 twin shares the stimulus.
module tb_scoreboard_regfile;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR-1:0]   rd_use = '0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            iss_en = 1'b0;
    logic [AW-1:0]   iss_addr = '0;
    logic            flush = 1'b0;

    logic [NR*DW-1:0] rd_data,    nb_rd_data;
    logic [NR-1:0]    rd_pending, nb_rd_pending;
    logic             stall,      nb_stall;
    logic [7:0]       pending_mask, nb_pending_mask;
    logic             iss_ovf,    nb_iss_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scoreboard_regfile #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_use(rd_use),
        .rd_data(rd_data), .rd_pending(rd_pending), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .pending_mask(pending_mask), .iss_ovf(iss_ovf)
    );

    scoreboard_regfile #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_use(rd_use),
        .rd_data(nb_rd_data), .rd_pending(nb_rd_pending), .stall(nb_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .pending_mask(nb_pending_mask), .iss_ovf(nb_iss_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_mask", pending_mask, 32'h0);
        check("reset_ovf", iss_ovf, 32'h0);
        check("reset_stall", stall, 32'h0);
        #1 rst_n = 1'b1;

        // Plain write then read on port 1
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        next_cycle();
        wr_en = 1'b0; rd_addr = {3'd3, 3'd0};
        @(negedge clk);
        check("r3_read_p1", rd_data[31:16], 32'h1234);
        check("r3_mask", pending_mask, 32'h0);
        next_cycle();

        // Register 0 ignores writes, even forwarded ones
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        @(negedge clk);
        check("r0_bypass_zero", rd_data[15:0], 32'h0);
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        check("r0_read_zero", rd_data[15:0], 32'h0);
        next_cycle();
        iss_en = 1'b1; iss_addr = 3'd0;
        next_cycle();
        iss_en = 1'b0;
        @(negedge clk);
        check("r0_not_pending", pending_mask, 32'h0);
        check("r0_no_ovf", iss_ovf, 32'h0);

        // RAW on r5: stall, then resolve with and without bypass
        next_cycle();
        iss_en = 1'b1; iss_addr = 3'd5;
        @(negedge clk);
        check("r5_issue_not_yet", pending_mask, 32'h0);
        next_cycle();
        iss_en = 1'b0; rd_addr = {3'd0, 3'd5}; rd_use = 2'b01;
        @(negedge clk);
        check("r5_stall", stall, 32'h1);
        check("r5_mask", pending_mask, 32'h20);
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hABCD;
        @(negedge clk);
        check("r5_bypass_data", rd_data[15:0], 32'hABCD);
        check("r5_bypass_pend", rd_pending[0], 32'h0);
        check("r5_bypass_stall", stall, 32'h0);
        check("r5_nb_stall_wb", nb_stall, 32'h1);
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        check("r5_nb_stall_after", nb_stall, 32'h0);
        check("r5_nb_data", nb_rd_data[15:0], 32'hABCD);
        check("r5_mask_clear", pending_mask, 32'h0);

        // Counter saturation on r2
        next_cycle();
        rd_use = 2'b00; rd_addr = {3'd0, 3'd2};
        iss_en = 1'b1; iss_addr = 3'd2;
        repeat (3) next_cycle();
        @(negedge clk);
        check("r2_no_ovf_yet", iss_ovf, 32'h0);
        next_cycle();
        iss_en = 1'b0;
        @(negedge clk);
        check("r2_ovf", iss_ovf, 32'h1);
        check("r2_mask", pending_mask, 32'h04);
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0002;
        next_cycle();
        wr_data = 16'h0003;
        @(negedge clk);
        check("r2_still_pend", rd_pending[0], 32'h1);
        next_cycle();
        wr_data = 16'h0004;
        @(negedge clk);
        check("r2_last_bypass_pend", rd_pending[0], 32'h0);
        check("r2_last_nb_pend", nb_rd_pending[0], 32'h1);
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        check("r2_mask_clear", pending_mask, 32'h0);
        check("r2_ovf_sticky", iss_ovf, 32'h1);
        check("r2_data", rd_data[15:0], 32'h0004);
        next_cycle();
        wr_en = 1'b1; wr_data = 16'h0055;
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        check("r2_untracked_data", rd_data[15:0], 32'h0055);
        check("r2_untracked_mask", pending_mask, 32'h0);

        // Simultaneous issue/write, then flush
        next_cycle();
        iss_en = 1'b1; iss_addr = 3'd4;
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0011;
        next_cycle();
        iss_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("r4_inc_dec_hold", pending_mask, 32'h10);
        next_cycle();
        flush = 1'b1; iss_en = 1'b1; iss_addr = 3'd6;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0042;
        next_cycle();
        flush = 1'b0; iss_en = 1'b0; wr_en = 1'b0;
        rd_addr = {3'd6, 3'd4};
        @(negedge clk);
        check("flush_mask", pending_mask, 32'h0);
        check("flush_r6_pend", rd_pending[1], 32'h0);
        check("flush_r4_data", rd_data[15:0], 32'h0042);
        check("flush_keeps_ovf", iss_ovf, 32'h1);

        // Asynchronous reset mid-cycle
        next_cycle();
        iss_en = 1'b1; iss_addr = 3'd1;
        next_cycle();
        iss_addr = 3'd7;
        next_cycle();
        iss_en = 1'b0; rd_addr = {3'd4, 3'd1}; rd_use = 2'b01;
        @(negedge clk);
        check("pre_rst_mask", pending_mask, 32'h82);
        check("pre_rst_stall", stall, 32'h1);
        check("pre_rst_r4", rd_data[31:16], 32'h0042);
        next_cycle();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_mask", pending_mask, 32'h0);
        check("async_rst_stall", stall, 32'h0);
        check("async_rst_data", rd_data, 32'h0);
        check("async_rst_ovf", iss_ovf, 32'h0);
        #1 rst_n = 1'b1;

        // Operation resumes from the reset state
        next_cycle();
        iss_en = 1'b1; iss_addr = 3'd1;
        next_cycle();
        iss_en = 1'b0;
        @(negedge clk);
        check("resume_mask", pending_mask, 32'h02);
        next_cycle();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h7777;
        @(negedge clk);
        check("resume_bypass", rd_data[15:0], 32'h7777);
        check("resume_stall", stall, 32'h0);
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        check("resume_data", rd_data[15:0], 32'h7777);
        check("resume_mask_clear", pending_mask, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
Name: scoreboard_regfile

Overview:
- Parametrised register file with an integrated write scoreboard.
- Replaces the constant-output register stub in the decode stage; serves NUM_RD combinational read ports.
- Tracks outstanding writes per register with small in-flight counters, so decode can stall on RAW hazards without a separate hazard unit.
- Sits in decode: issue marks destinations pending, writeback clears them.

Parameters:
- DATA_W, 16, register and data width
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W
- NUM_RD, 2, number of read ports
- CNT_W, 2, width of per-register in-flight counter; max count 2**CNT_W-1
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never pending
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; pending cleared in the resolving cycle

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_use  in  NUM_RD  port i operand is actually consumed by the decoding instruction
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_pending  out  NUM_RD  read register has an unresolved write
- stall  out  1  OR over i of (rd_use[i] AND rd_pending[i])
- wr_en  in  1  writeback enable
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  instruction with destination issued this cycle
- iss_addr  in  ADDR_W  issued destination
- flush  in  1  clear all pending counts (pipeline squash)
- pending_mask  out  NREGS  bit r = (cnt[r] != 0); decoded from state regs
- iss_ovf  out  1  sticky: issue to a register whose counter was already at max

Behaviour:
- Reset (async, rst_n=0): all registers 0; all cnt 0; iss_ovf 0; pending_mask 0. With no read-port write match, rd_data reads 0, and rd_pending and stall read 0.
- Write: on the rising edge with wr_en=1, reg[wr_addr] <= wr_data.
  - With ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read (combinational, zero latency):
  - ZERO_REG=1 and addr 0 -> 0.
  - Else, BYPASS=1, wr_en=1, wr_addr==rd_addr -> wr_data.
  - Else reg[rd_addr].
  - Each port is independent; duplicate addresses are legal.
- Counter update per register r at each edge; inc = iss_en AND iss_addr==r; dec = wr_en AND wr_addr==r AND cnt[r]!=0.
  - flush=1 -> cnt[r] <= 0 for all r. Overrides inc and dec; the register write still occurs.
  - inc and dec together -> unchanged.
  - inc only -> +1. If cnt is already max: held at max and iss_ovf <= 1.
  - dec only -> -1.
  - A write to a register with cnt 0 is an untracked write: legal, data written, cnt stays 0, no error.
  - With ZERO_REG=1, issue to register 0 is ignored: no count, no overflow.
- rd_pending[i] = cnt[a] != 0, except 0 when BYPASS=1, wr_en=1, wr_addr==a and cnt[a]==1 (last outstanding write resolving, data forwarded).
  - With BYPASS=0, pending persists through the writeback cycle.
  - Same-cycle issue does not affect rd_pending; it takes effect from the next cycle.
  - Register 0 is never pending when ZERO_REG=1.
- stall is purely combinational from rd_use and rd_pending. The block does not gate iss_en; the caller must not assert iss_en while stall=1.
- iss_ovf: cleared only by reset; flush does not clear it.
- Reset asserted mid-operation: counts and data clear immediately; resumes from the reset state on the first edge after release.
- Implementation: state held in per-register arrays; read muxing generated over NUM_RD.

Test Plan:
- Reset, then write r3=0x1234 and read r3 on port 1 the next cycle -> rd_data port 1 = 0x1234; pending_mask=0.
- Write r0=0xFFFF with ZERO_REG=1, then read r0 -> 0x0000. Issue to r0 -> pending_mask bit0 stays 0; iss_ovf stays 0.
- Issue r5, then with rd_addr0=5 and rd_use0=1 -> stall=1 next cycle.
  - BYPASS=1: in the wr_en r5=0xABCD cycle, rd_data0=0xABCD, rd_pending0=0, stall=0.
  - BYPASS=0: stall stays 1 that cycle and drops the following cycle.
- Issue r2 four times (CNT_W=2) -> cnt held at 3, iss_ovf=1. Three writes to r2 -> pending_mask bit2=0; iss_ovf still 1.
- Issue r4 and write r4 in the same cycle with cnt[r4]=1 -> cnt stays 1. Then flush together with iss r6 -> pending_mask=0 and r6 not pending; a concurrent write r4=0x0042 is stored.
- Issue r1 and r7, then pulse rst_n low asynchronously mid-cycle -> all outputs 0 immediately, before the next clk edge.
